// File: rtl/spi_flash_seq.sv
// spi_flash_seq
// Host-side command sequencer for the SPI flash path. Takes one read / erase /
// program request at a time, expands it into the opcode sequence that
// flash_ctrl executes (optional write-enable prefix, main opcode, timed wait
// for the flash's internal operation), and returns read data.
//
// Ports
//   sys_clk, sys_rst   single clock, asynchronous active-high reset
//   req_valid/ready    request handshake; transfer when both are high
//   req_op             0 read word, 1 sector erase, 2 block erase, 3 page program
//   req_adr            flash byte address
//   rsp_valid          one-cycle completion pulse
//   rsp_err            with rsp_valid: controller never acknowledged (timeout)
//   rsp_dat            read data with rsp_valid for op 0, otherwise holds
//   fsm_cmd            to controller: FSM_ACT starts an opcode, FSM_IDLE otherwise
//   spi_cmd, spi_adr   to controller: opcode and address, stable while active
//   spi_cs_n           from controller: low while an opcode is being shifted
//   spi_dat            from controller: shift register contents
//   dbg_state          current FSM state, for observation only
//
// Handshake: req_valid/req_ready follow strict valid/ready rules. A request
// transfers on a rising sys_clk edge where both are high; the requester keeps
// req_valid and its payload stable until that edge, and req_ready never
// depends combinationally on req_valid. rsp_valid is a single-cycle pulse
// with no back-pressure.
module spi_flash_seq #(
    parameter logic [31:0] SECTOR_ERASE_CYC = 32'd20_000_000,
    parameter logic [31:0] BLOCK_ERASE_CYC  = 32'd100_000_000,
    parameter logic [31:0] PAGE_PGM_CYC     = 32'd150_000,
    parameter logic [7:0]  CS_GAP_CYC       = 8'd16,
    parameter logic [15:0] ACK_TIMEOUT      = 16'd1024,
    // Controller encodings, matching spi_flash_params.vh
    parameter logic [1:0]  FSM_IDLE         = 2'd0,
    parameter logic [1:0]  FSM_ACT          = 2'd1,
    parameter logic [7:0]  SPI_FAST_READ    = 8'h0B,
    parameter logic [7:0]  SPI_WRITE_ENABLE = 8'h06,
    parameter logic [7:0]  SPI_SECTOR_ERASE = 8'h20,
    parameter logic [7:0]  SPI_BLOCK_ERASE  = 8'hD8,
    parameter logic [7:0]  SPI_PAGE_PGM     = 8'h02
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [23:0] req_adr,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_dat,
    output logic [1:0]  fsm_cmd,
    output logic [7:0]  spi_cmd,
    output logic [23:0] spi_adr,
    input  logic        spi_cs_n,
    input  logic [31:0] spi_dat,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACT   = 3'd1,
        S_XFER  = 3'd2,
        S_GAP   = 3'd3,
        S_TIMED = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [1:0] OP_READ = 2'd0;

    state_t      state;
    logic [1:0]  op_q;
    logic        pre;        // write-enable prefix still to be sent
    logic        cs_q;       // spi_cs_n through one register
    logic        cs_prev;    // previous value of cs_q
    logic        cs_rise;
    logic [15:0] ack_cnt;
    logic [7:0]  gap_cnt;
    logic [31:0] wait_cnt;
    logic [7:0]  main_cmd;
    logic [31:0] wait_load;
    logic        ack_expired;
    logic        gap_done;

    assign cs_rise   = cs_q & ~cs_prev;
    assign dbg_state = state;

    // Widened compares so that a zero parameter still ends after one cycle
    // instead of wrapping the counter.
    assign ack_expired = ({1'b0, ack_cnt} + 17'd1) >= {1'b0, ACK_TIMEOUT};
    assign gap_done    = ({1'b0, gap_cnt} + 9'd1)  >= {1'b0, CS_GAP_CYC};

    always_comb begin
        main_cmd  = SPI_FAST_READ;
        wait_load = 32'd0;
        case (op_q)
            2'd1: begin main_cmd = SPI_SECTOR_ERASE; wait_load = SECTOR_ERASE_CYC; end
            2'd2: begin main_cmd = SPI_BLOCK_ERASE;  wait_load = BLOCK_ERASE_CYC;  end
            2'd3: begin main_cmd = SPI_PAGE_PGM;     wait_load = PAGE_PGM_CYC;     end
            default: begin main_cmd = SPI_FAST_READ; wait_load = 32'd0; end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= S_IDLE;
            op_q      <= 2'd0;
            pre       <= 1'b0;
            cs_q      <= 1'b1;
            cs_prev   <= 1'b1;
            ack_cnt   <= 16'd0;
            gap_cnt   <= 8'd0;
            wait_cnt  <= 32'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_dat   <= 32'd0;
            fsm_cmd   <= FSM_IDLE;
            spi_cmd   <= 8'd0;
            spi_adr   <= 24'd0;
        end else begin
            cs_q    <= spi_cs_n;
            cs_prev <= cs_q;
            case (state)
                S_IDLE: begin
                    if (req_ready && req_valid) begin
                        req_ready <= 1'b0;
                        op_q      <= req_op;
                        spi_adr   <= req_adr;
                        pre       <= (req_op != OP_READ);
                        spi_cmd   <= (req_op == OP_READ) ? SPI_FAST_READ : SPI_WRITE_ENABLE;
                        ack_cnt   <= 16'd0;
                        fsm_cmd   <= FSM_ACT;
                        state     <= S_ACT;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_ACT: begin
                    if (!cs_q) begin
                        fsm_cmd <= FSM_IDLE;
                        state   <= S_XFER;
                    end else if (ack_expired) begin
                        // Controller never started: abandon the whole request.
                        fsm_cmd   <= FSM_IDLE;
                        pre       <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        ack_cnt <= ack_cnt + 16'd1;
                    end
                end
                S_XFER: begin
                    if (cs_rise) begin
                        if (pre) begin
                            pre     <= 1'b0;
                            spi_cmd <= main_cmd;
                            gap_cnt <= 8'd0;
                            state   <= S_GAP;
                        end else if (op_q == OP_READ) begin
                            rsp_dat   <= spi_dat;
                            rsp_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            wait_cnt <= wait_load;
                            state    <= S_TIMED;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_done) begin
                        ack_cnt <= 16'd0;
                        fsm_cmd <= FSM_ACT;
                        state   <= S_ACT;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                S_TIMED: begin
                    if (wait_cnt == 32'd0) begin
                        rsp_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 32'd1;
                    end
                end
                S_DONE: begin
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    fsm_cmd <= FSM_IDLE;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_seq.sv
module tb_spi_flash_seq;

    localparam logic [1:0] FSM_IDLE         = 2'd0;
    localparam logic [1:0] FSM_ACT          = 2'd1;
    localparam logic [7:0] SPI_FAST_READ    = 8'h0B;
    localparam logic [7:0] SPI_WRITE_ENABLE = 8'h06;
    localparam logic [7:0] SPI_SECTOR_ERASE = 8'h20;
    localparam logic [7:0] SPI_BLOCK_ERASE  = 8'hD8;
    localparam logic [7:0] SPI_PAGE_PGM     = 8'h02;

    localparam int SE_CYC  = 50;
    localparam int BE_CYC  = 400;
    localparam int PP_CYC  = 0;
    localparam int GAP_CYC = 16;
    localparam int ACK_CYC = 8;
    localparam int BUDGET  = 8000;

    logic        sys_clk;
    logic        sys_rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [23:0] req_adr;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_dat;
    logic [1:0]  fsm_cmd;
    logic [7:0]  spi_cmd;
    logic [23:0] spi_adr;
    logic        spi_cs_n;
    logic [31:0] spi_dat;
    logic [2:0]  dbg_state;

    spi_flash_seq #(
        .SECTOR_ERASE_CYC(32'(SE_CYC)),
        .BLOCK_ERASE_CYC (32'(BE_CYC)),
        .PAGE_PGM_CYC    (32'(PP_CYC)),
        .CS_GAP_CYC      (8'(GAP_CYC)),
        .ACK_TIMEOUT     (16'(ACK_CYC))
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_adr  (req_adr),
        .rsp_valid(rsp_valid),
        .rsp_err  (rsp_err),
        .rsp_dat  (rsp_dat),
        .fsm_cmd  (fsm_cmd),
        .spi_cmd  (spi_cmd),
        .spi_adr  (spi_adr),
        .spi_cs_n (spi_cs_n),
        .spi_dat  (spi_dat),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / cycle count ----------------
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int unsigned cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];      // expected {opcode, address} per SPI operation
    logic [31:0] seen_q[$];     // observed by the controller model
    logic [32:0] exp_rsp_q[$];  // expected {err, data}
    logic [32:0] rsp_q[$];      // observed responses
    int unsigned rsp_cyc_q[$];
    int          gap_q[$];      // chip-select-high cycles before each opcode
    logic [31:0] rd_q[$];       // data the controller model returns for reads
    logic [31:0] model_dat = 32'd0;
    int          acc_cnt   = 0;

    // ---------------- controller model ----------------
    logic        ctl_en   = 1'b1;
    int unsigned last_rise = 0;
    int          unstable  = 0;
    int          ctl_d;
    int          ctl_len;
    logic [7:0]  ctl_c;
    logic [23:0] ctl_a;

    always begin
        @(posedge sys_clk); #1;
        if (!sys_rst && ctl_en && fsm_cmd == FSM_ACT && spi_cs_n) begin
            ctl_d = $urandom_range(0, 3);
            for (int i = 0; i < ctl_d; i++) begin @(posedge sys_clk); #1; end
            if (!sys_rst) begin
                ctl_c = spi_cmd;
                ctl_a = spi_adr;
                seen_q.push_back({ctl_c, ctl_a});
                gap_q.push_back(int'(cyc - last_rise) - ctl_d);
                spi_cs_n = 1'b0;
                case (ctl_c)
                    SPI_WRITE_ENABLE: ctl_len = 8;
                    SPI_FAST_READ:    ctl_len = 72;
                    SPI_PAGE_PGM:     ctl_len = 2080;
                    default:          ctl_len = 32;
                endcase
                for (int i = 0; i < ctl_len && !sys_rst; i++) begin
                    @(posedge sys_clk); #1;
                    if (!sys_rst && (spi_cmd !== ctl_c || spi_adr !== ctl_a)) unstable++;
                end
                if (ctl_c == SPI_FAST_READ && rd_q.size() > 0) spi_dat = rd_q.pop_front();
                else spi_dat = $urandom;
                spi_cs_n  = 1'b1;
                last_rise = cyc;
            end
        end
    end

    // ---------------- response / accept monitor ----------------
    always @(negedge sys_clk) begin
        if (!sys_rst && rsp_valid) begin
            rsp_q.push_back({rsp_err, rsp_dat});
            rsp_cyc_q.push_back(cyc);
        end
        if (!sys_rst && req_valid && req_ready) acc_cnt++;
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: opcode sequence and response per request.
    task automatic model_req(input logic [1:0] op, input logic [23:0] adr,
                             input logic [31:0] rd, input bit with_rsp);
        case (op)
            2'd0: begin
                exp_q.push_back({SPI_FAST_READ, adr});
                model_dat = rd;
            end
            2'd1: begin
                exp_q.push_back({SPI_WRITE_ENABLE, adr});
                exp_q.push_back({SPI_SECTOR_ERASE, adr});
            end
            2'd2: begin
                exp_q.push_back({SPI_WRITE_ENABLE, adr});
                exp_q.push_back({SPI_BLOCK_ERASE, adr});
            end
            default: begin
                exp_q.push_back({SPI_WRITE_ENABLE, adr});
                exp_q.push_back({SPI_PAGE_PGM, adr});
            end
        endcase
        if (with_rsp) exp_rsp_q.push_back({1'b0, model_dat});
    endtask

    // Cycles from chip-select release to rsp_valid: one to register spi_cs_n,
    // one to see the edge, then wait+1 TIMED cycles for erase/program.
    function automatic int exp_lat(input logic [1:0] op);
        case (op)
            2'd0:    return 2;
            2'd1:    return SE_CYC + 3;
            2'd2:    return BE_CYC + 3;
            default: return PP_CYC + 3;
        endcase
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1'b0);
        chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk({tag, "_rsp_err"},   rsp_err,   1'b0);
        chk({tag, "_rsp_dat"},   rsp_dat,   32'd0);
        chk({tag, "_fsm_cmd"},   fsm_cmd,   FSM_IDLE);
        chk({tag, "_spi_cmd"},   spi_cmd,   8'd0);
        chk({tag, "_spi_adr"},   spi_adr,   24'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [1:0] op, input logic [23:0] adr,
                         input bit hold, output int unsigned acc);
        int t;
        t = 0;
        req_op    = op;
        req_adr   = adr;
        req_valid = 1'b1;
        while (req_ready !== 1'b1 && t < BUDGET) begin @(posedge sys_clk); #1; t++; end
        chk("accept_budget", (t < BUDGET), 1'b1);
        @(posedge sys_clk); #1;
        acc = cyc;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n);
        int t;
        t = 0;
        while (rsp_q.size() < n && t < BUDGET) begin @(posedge sys_clk); #1; t++; end
        chk("rsp_budget", (t < BUDGET), 1'b1);
    endtask

    task automatic drain();
        while (exp_q.size() > 0) begin
            if (seen_q.size() == 0) chk("opcode_missing", 64'd0, {32'd0, exp_q.pop_front()});
            else chk("opcode_adr", seen_q.pop_front(), exp_q.pop_front());
        end
        chk("opcode_extra", seen_q.size(), 0);
        seen_q.delete();
        while (exp_rsp_q.size() > 0) begin
            if (rsp_q.size() == 0) chk("rsp_missing", 64'h1_0000_0000_0000, {31'd0, exp_rsp_q.pop_front()});
            else chk("rsp_err_dat", rsp_q.pop_front(), exp_rsp_q.pop_front());
        end
        chk("rsp_extra", rsp_q.size(), 0);
        chk("cmd_adr_stable", unstable, 0);
        rsp_q.delete();
        rsp_cyc_q.delete();
        gap_q.delete();
    endtask

    task automatic do_req(input logic [1:0] op, input logic [23:0] adr, input logic [31:0] rd);
        int unsigned acc;
        if (op == 2'd0) rd_q.push_back(rd);
        model_req(op, adr, rd, 1'b1);
        issue(op, adr, 1'b0, acc);
        chk("fsm_act_after_accept", fsm_cmd, FSM_ACT);
        chk("ready_low_after_accept", req_ready, 1'b0);
        wait_rsp(1);
        chk("rsp_single_pulse", rsp_valid, 1'b0);
        chk("ready_after_rsp", req_ready, 1'b1);
        if (rsp_cyc_q.size() > 0) chk("rsp_latency", rsp_cyc_q[0] - last_rise, exp_lat(op));
        if (op != 2'd0 && gap_q.size() >= 2) chk("cs_gap", gap_q[1], GAP_CYC + 2);
        drain();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int unsigned acc;
        int          t;
        int          acc_before;
        logic [1:0]  op;
        logic [23:0] adr;
        logic [31:0] rd;

        sys_rst   = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'd0;
        req_adr   = 24'd0;
        spi_cs_n  = 1'b1;
        spi_dat   = 32'd0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_vals("reset");
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        chk("ready_after_release", req_ready, 1'b1);

        // Read at 0x012345 returning 0xDEADBEEF
        do_req(2'd0, 24'h012345, 32'hDEADBEEF);
        // Sector erase at 0x001000
        do_req(2'd1, 24'h001000, 32'd0);
        // Page program, zero wait
        do_req(2'd3, 24'($urandom), 32'd0);

        // Random mix
        for (int i = 0; i < 8; i++) begin
            op  = 2'($urandom_range(0, 3));
            adr = 24'($urandom);
            rd  = $urandom;
            do_req(op, adr, rd);
        end

        // Controller never answers: timeout, then a normal request
        ctl_en = 1'b0;
        exp_rsp_q.push_back({1'b1, model_dat});
        issue(2'd0, 24'h0ABCDE, 1'b0, acc);
        wait_rsp(1);
        if (rsp_cyc_q.size() > 0) chk("timeout_latency", rsp_cyc_q[0] - acc, ACK_CYC);
        drain();
        ctl_en = 1'b1;
        do_req(2'd0, 24'h000100, $urandom);

        // Reset during the timed wait of a block erase
        adr = 24'($urandom);
        model_req(2'd2, adr, 32'd0, 1'b0);
        issue(2'd2, adr, 1'b0, acc);
        t = 0;
        while (!(seen_q.size() == 2 && spi_cs_n) && t < BUDGET) begin @(posedge sys_clk); #1; t++; end
        chk("be_opcode_budget", (t < BUDGET), 1'b1);
        repeat (20) @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        model_dat = 32'd0;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        @(posedge sys_clk); #1;
        chk("ready_after_mid_reset", req_ready, 1'b1);
        drain();
        do_req(2'd0, 24'h123456, $urandom);

        // req_valid held high, alternating read / page program
        acc_before = acc_cnt;
        for (int i = 0; i < 4; i++) begin
            op  = (i % 2 == 1) ? 2'd3 : 2'd0;
            adr = 24'($urandom);
            rd  = $urandom;
            if (op == 2'd0) rd_q.push_back(rd);
            model_req(op, adr, rd, 1'b1);
            issue(op, adr, (i < 3), acc);
        end
        wait_rsp(4);
        @(posedge sys_clk); #1;
        chk("held_accepts", acc_cnt - acc_before, 4);
        chk("held_responses", rsp_q.size(), 4);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
